// File: rtl/s_cla_nibble_seq_if.sv
// Operand/result handshake bundle for s_cla_nibble_seq: valid/ready in, valid/ready out.
interface s_cla_nibble_seq_if #(parameter int N = 16);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [N:0]   out;
  logic         ovf;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, out, ovf
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, out, ovf
  );
endinterface

// File: rtl/s_cla_nibble_seq.sv
// Sequenced signed adder: one 4-bit CLA slice reused over N/4 cycles with a registered carry.
// Optional macro S_CLA_SEQ_OVF_EN builds the signed-overflow output; otherwise ovf is tied 0.
module s_cla_nibble_seq #(
  parameter int N = 16
) (
  input  logic              clk,
  input  logic              rst,
  s_cla_nibble_seq_if.slave bus
);
  localparam int NIB = N / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  generate
    if ((N % 4) != 0 || N < 4) begin : g_bad_n
      $error("s_cla_nibble_seq: N must be a multiple of 4 and >= 4");
    end
  endgenerate

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  a_q, a_d, b_q, b_d;
  logic [N-1:0]  res_q, res_d, res_sh;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          c_q, c_d;
  logic          sa_q, sa_d, sb_q, sb_d;
  logic [N:0]    out_q, out_d;

  // 4-bit carry-lookahead slice on the low nibble of the shift registers
  logic [3:0] g, p, s;
  logic       c1, c2, c3, c4;

  always_comb begin
    g  = a_q[3:0] & b_q[3:0];
    p  = a_q[3:0] ^ b_q[3:0];
    c1 = g[0] | (p[0] & c_q);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_q);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_q);
    c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
       | (p[3] & p[2] & p[1] & p[0] & c_q);
    s  = p ^ {c3, c2, c1, c_q};
  end

  // Result fills from the top nibble downward, so after N/4 shifts nibble 0 sits at the bottom
  generate
    if (N == 4) begin : g_res_n4
      assign res_sh = s;
    end else begin : g_res_nw
      assign res_sh = {s, res_q[N-1:4]};
    end
  endgenerate

`ifdef S_CLA_SEQ_OVF_EN
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    out_d   = out_q;
`ifdef S_CLA_SEQ_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: if (bus.in_valid) begin
        a_d     = bus.a;
        b_d     = bus.b;
        c_d     = 1'b0;
        cnt_d   = '0;
        sa_d    = bus.a[N-1];
        sb_d    = bus.b[N-1];
        state_d = RUN;
      end
      RUN: begin
        a_d   = a_q >> 4;
        b_d   = b_q >> 4;
        c_d   = c4;
        cnt_d = cnt_q + 1'b1;
        res_d = res_sh;
        if (cnt_q == LAST) begin
          out_d   = {sa_q ^ sb_q ^ c4, res_sh};
`ifdef S_CLA_SEQ_OVF_EN
          ovf_d   = c3 ^ c4;
`endif
          state_d = DONE;
        end
      end
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      out_q   <= out_d;
    end
  end

`ifdef S_CLA_SEQ_OVF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end
  assign bus.ovf = ovf_q;
`else
  assign bus.ovf = 1'b0;
`endif

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out       = out_q;
endmodule

// File: tb/tb_s_cla_nibble_seq.sv
// Directed-vector and stream bench for s_cla_nibble_seq at N=16.
module tb_s_cla_nibble_seq;
  localparam int N = 16;
`ifdef S_CLA_SEQ_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  s_cla_nibble_seq_if #(.N(N)) bus_if ();
  s_cla_nibble_seq #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus_if));

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [16:0] exp_out;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[12];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Accept one operand pair, measure latency, check result, then complete the handshake
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic [16:0] eo, input logic eovf, input string name);
    int lat;
    chk({name, " in_ready"}, 32'(bus_if.in_ready), 32'd1);
    bus_if.a = a; bus_if.b = b; bus_if.in_valid = 1'b1;
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
    lat = 0;
    while (!bus_if.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, " latency"}, 32'(lat), 32'd4);
    chk({name, " out"}, 32'(bus_if.out), 32'(eo));
    chk({name, " ovf"}, 32'(bus_if.ovf), 32'(eovf & OVF_ON));
    bus_if.out_ready = 1'b1;
    @(posedge clk); #1;
    bus_if.out_ready = 1'b0;
    chk({name, " idle"}, 32'(bus_if.in_ready), 32'd1);
  endtask

  initial begin
    logic [15:0] ra, rb, ts;
    logic [16:0] rexp;
    logic        rovf;

    vecs[0]  = '{16'h7FFF, 16'h0001, 17'h08000, 1'b1};
    vecs[1]  = '{16'h8000, 16'h8000, 17'h10000, 1'b1};
    vecs[2]  = '{16'hFFFF, 16'h0001, 17'h00000, 1'b0};
    vecs[3]  = '{16'h0001, 16'h0002, 17'h00003, 1'b0};
    vecs[4]  = '{16'h1234, 16'h1111, 17'h02345, 1'b0};
    vecs[5]  = '{16'h7FFF, 16'h7FFF, 17'h0FFFE, 1'b1};
    vecs[6]  = '{16'h8000, 16'hFFFF, 17'h17FFF, 1'b1};
    vecs[7]  = '{16'hFFFE, 16'hFFFE, 17'h1FFFC, 1'b0};
    vecs[8]  = '{16'h0F0F, 16'h00F1, 17'h01000, 1'b0};
    vecs[9]  = '{16'h0003, 16'hFFFE, 17'h00001, 1'b0};
    vecs[10] = '{16'h0000, 16'h0000, 17'h00000, 1'b0};
    vecs[11] = '{16'h8000, 16'h7FFF, 17'h1FFFF, 1'b0};

    bus_if.in_valid = 1'b0; bus_if.out_ready = 1'b0;
    bus_if.a = '0; bus_if.b = '0;
    rst = 1'b1;
    bus_if.in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready", 32'(bus_if.in_ready), 32'd1);
    chk("reset out_valid", 32'(bus_if.out_valid), 32'd0);
    chk("reset out", 32'(bus_if.out), 32'd0);
    chk("reset ovf", 32'(bus_if.ovf), 32'd0);
    bus_if.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].exp_out, vecs[i].exp_ovf, $sformatf("vec%0d", i));

    // Back-pressure: result held in DONE while new operands are offered
    bus_if.a = 16'h7FFF; bus_if.b = 16'h0001; bus_if.in_valid = 1'b1;
    @(posedge clk); #1;
    bus_if.a = 16'h1234; bus_if.b = 16'h1111;
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp valid c%0d", i), 32'(bus_if.out_valid), 32'd1);
      chk($sformatf("bp out c%0d", i), 32'(bus_if.out), 32'h08000);
      chk($sformatf("bp in_ready c%0d", i), 32'(bus_if.in_ready), 32'd0);
      @(posedge clk); #1;
    end
    bus_if.out_ready = 1'b1;
    @(posedge clk); #1;
    bus_if.out_ready = 1'b0;
    chk("bp idle", 32'(bus_if.in_ready), 32'd1);
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("bp next valid", 32'(bus_if.out_valid), 32'd1);
    chk("bp next out", 32'(bus_if.out), 32'h02345);
    bus_if.out_ready = 1'b1;
    @(posedge clk); #1;
    bus_if.out_ready = 1'b0;

    // Reset in the 2nd RUN cycle discards the operation
    bus_if.a = 16'h0F0F; bus_if.b = 16'h00F1; bus_if.in_valid = 1'b1;
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst mid out_valid", 32'(bus_if.out_valid), 32'd0);
    chk("rst mid out", 32'(bus_if.out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst release in_ready", 32'(bus_if.in_ready), 32'd1);
    @(posedge clk); #1;
    run_op(16'h0003, 16'hFFFE, 17'h00001, 1'b0, "post-rst");

    // Stream: out_ready tied high, one accept every 6 cycles
    bus_if.out_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 10 == 0) ra = ($urandom_range(0, 1) != 0) ? 16'h8000 : 16'h7FFF;
      if (i % 10 == 5) rb = ($urandom_range(0, 1) != 0) ? 16'h8000 : 16'h7FFF;
      rexp = {ra[15], ra} + {rb[15], rb};
      ts   = ra + rb;
      rovf = (ra[15] == rb[15]) && (ts[15] != ra[15]);
      chk("stream in_ready", 32'(bus_if.in_ready), 32'd1);
      bus_if.a = ra; bus_if.b = rb; bus_if.in_valid = 1'b1;
      @(posedge clk); #1;
      repeat (4) @(posedge clk);
      #1;
      chk("stream valid", 32'(bus_if.out_valid), 32'd1);
      chk($sformatf("stream out %h+%h", ra, rb), 32'(bus_if.out), 32'(rexp));
      chk($sformatf("stream ovf %h+%h", ra, rb), 32'(bus_if.ovf), 32'(rovf & OVF_ON));
      @(posedge clk); #1;
    end
    bus_if.in_valid = 1'b0;
    bus_if.out_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
